writeback_queue: RTL and testbench
==================================

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of pending writeback entries; SHALL be a power of two, at least 2.
REQ-002 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 mem_valid  input  1  load-unit writeback request.
REQ-005 mem_rd  input  5  load destination register.
REQ-006 mem_data  input  32  load result.
REQ-007 mem_ready  output  1  load request accepted when mem_valid && mem_ready.
REQ-008 alu_valid  input  1  ALU writeback request.
REQ-009 alu_rd  input  5  ALU destination register.
REQ-010 alu_data  input  32  ALU result.
REQ-011 alu_ready  output  1  ALU request accepted when alu_valid && alu_ready.
REQ-012 drain_en  input  1  register-file write port available this cycle.
REQ-013 flush  input  1  discard all pending entries.
REQ-014 rf_we  output  1  register-file write enable.
REQ-015 rf_addr  output  5  register-file write address.
REQ-016 rf_wd  output  32  register-file write data.
REQ-017 q_addr1, q_addr2  input  5 each  bypass lookup addresses.
REQ-018 hit1, hit2  output  1 each  pending write exists for q_addr1 / q_addr2.
REQ-019 fwd1, fwd2  output  32 each  bypass data for q_addr1 / q_addr2.
REQ-020 count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-021 Queue SHALL be in-order FIFO of {rd[4:0], data[31:0]} entries, circular read/write pointers wrapping from DEPTH-1 to 0.
REQ-022 At most one entry SHALL be accepted per cycle; mem has priority over alu.
REQ-023 mem_ready SHALL equal !rst && !flush && (count < DEPTH).
REQ-024 alu_ready SHALL equal mem_ready && !mem_valid.
REQ-025 Full: count == DEPTH SHALL deassert both readies, even if a pop occurs the same cycle.
REQ-026 Accepted request with rd == 0 SHALL be handshaken but not enqueued; count unchanged by it.
REQ-027 rf_we SHALL equal (count != 0) && drain_en && !flush && !rst; rf_addr/rf_wd SHALL show the head entry (0 when empty).
REQ-028 Pop SHALL occur at the clock edge ending any cycle with rf_we = 1; head advances.
REQ-029 Latency: entry accepted in cycle N into an empty queue SHALL appear on rf_* in cycle N+1; one write per cycle thereafter while drain_en = 1.
REQ-030 Simultaneous push and pop SHALL leave count unchanged and both pointers advanced.
REQ-031 drain_en = 0 SHALL hold queue contents; pushes continue until full.
REQ-032 Bypass SHALL be combinational: hitK = 1 when q_addrK != 0 and any occupied entry matches; fwdK = data of youngest matching entry, else 0.
REQ-033 Bypass SHALL cover only registered entries; same-cycle incoming requests SHALL NOT hit.
REQ-034 Head entry being written this cycle SHALL still produce a hit.
REQ-035 flush SHALL, at the next edge, set count = 0 and both pointers = 0; it overrides push and pop that cycle (no rf_we, no accept).
REQ-036 count SHALL never exceed DEPTH or underflow below 0.

Reset
REQ-037 While rst = 1: mem_ready = alu_ready = rf_we = 0, hit1 = hit2 = 0.
REQ-038 After edge with rst = 1: count = 0, pointers = 0, rf_addr = 0, rf_wd = 0, fwd1 = fwd2 = 0; entry contents need not be cleared.
REQ-039 Reset asserted mid-drain SHALL discard all pending entries; no rf_we in reset cycle.

Verification
REQ-040 Single write: mem_valid, mem_rd=5, mem_data=0xDEADBEEF, drain_en=1 in cycle N -> cycle N+1 rf_we=1, rf_addr=5, rf_wd=0xDEADBEEF; count returns to 0 at N+2.
REQ-041 Priority: mem_valid (rd=3, 0x11) and alu_valid (rd=4, 0x22) same cycle -> mem accepted, alu_ready=0; alu accepted next cycle; writes rd=3 then rd=4 in order.
REQ-042 Full/wrap: drain_en=0, push DEPTH+1 entries rd=1..5 -> count=4, 5th stalled with mem_ready=0; drain_en=1 -> writes rd 1,2,3,4 then 5, pointers wrap cleanly.
REQ-043 Bypass: drain_en=0, push rd=7=0xA then rd=7=0xB -> q_addr1=7 gives hit1=1, fwd1=0xB; q_addr2=0 gives hit2=0.
REQ-044 x0 drop: alu_valid, alu_rd=0, alu_data=0xFFFFFFFF -> alu_ready=1, count stays 0, no rf_we.
REQ-045 Flush/reset: 3 pending entries, flush=1 with mem_valid=1 -> mem_ready=0, rf_we=0, count=0 next cycle; repeat with rst -> same result.

Source files
------------

// File: rtl/writeback_queue.sv
// writeback_queue: in-order FIFO that merges load-unit and ALU writebacks
// into a single register-file write port, with two combinational bypass lookups.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   mem_valid/mem_rd/mem_data      load writeback request (priority)
//   mem_ready                      load request accepted when valid && ready
//   alu_valid/alu_rd/alu_data      ALU writeback request
//   alu_ready                      ALU request accepted when valid && ready
//   drain_en                       register-file write port free this cycle
//   flush                          discard every pending entry
//   rf_we/rf_addr/rf_wd            register-file write port (head entry)
//   q_addr1/q_addr2                bypass lookup addresses
//   hit1/hit2, fwd1/fwd2           bypass hit flags and youngest matching data
//   count                          current occupancy
module writeback_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mem_valid,
    input  logic [4:0]                 mem_rd,
    input  logic [31:0]                mem_data,
    output logic                       mem_ready,
    input  logic                       alu_valid,
    input  logic [4:0]                 alu_rd,
    input  logic [31:0]                alu_data,
    output logic                       alu_ready,
    input  logic                       drain_en,
    input  logic                       flush,
    output logic                       rf_we,
    output logic [4:0]                 rf_addr,
    output logic [31:0]                rf_wd,
    input  logic [4:0]                 q_addr1,
    input  logic [4:0]                 q_addr2,
    output logic                       hit1,
    output logic                       hit2,
    output logic [31:0]                fwd1,
    output logic [31:0]                fwd2,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Entry storage is not reset; occupancy alone decides what is valid.
    logic [4:0]  rd_mem_q   [DEPTH];
    logic [31:0] data_mem_q [DEPTH];

    logic        push;
    logic        pop;
    logic [4:0]  in_rd;
    logic [31:0] in_data;
    logic [PW-1:0] lk_idx;

    // Handshake, drain port and next-state logic.
    always_comb begin
        mem_ready = !rst && !flush && (count_q < CW'(DEPTH));
        alu_ready = mem_ready && !mem_valid;
        in_rd     = mem_valid ? mem_rd : alu_rd;
        in_data   = mem_valid ? mem_data : alu_data;
        // Writes to x0 complete the handshake but never occupy a slot.
        push      = ((mem_valid && mem_ready) || (alu_valid && alu_ready)) && (in_rd != 5'd0);

        rf_we   = (count_q != '0) && drain_en && !flush && !rst;
        pop     = rf_we;
        rf_addr = '0;
        rf_wd   = '0;
        if (count_q != '0) begin
            rf_addr = rd_mem_q[rd_ptr_q];
            rf_wd   = data_mem_q[rd_ptr_q];
        end

        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Bypass: scan from head to tail so the youngest match wins.
    always_comb begin
        hit1   = 1'b0;
        hit2   = 1'b0;
        fwd1   = '0;
        fwd2   = '0;
        lk_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            lk_idx = rd_ptr_q + PW'(i);
            if (CW'(i) < count_q) begin
                if ((q_addr1 != 5'd0) && (rd_mem_q[lk_idx] == q_addr1)) begin
                    hit1 = 1'b1;
                    fwd1 = data_mem_q[lk_idx];
                end
                if ((q_addr2 != 5'd0) && (rd_mem_q[lk_idx] == q_addr2)) begin
                    hit2 = 1'b1;
                    fwd2 = data_mem_q[lk_idx];
                end
            end
        end
        if (rst) begin
            hit1 = 1'b0;
            hit2 = 1'b0;
            fwd1 = '0;
            fwd2 = '0;
        end
    end

    assign count = count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem_q[wr_ptr_q]   <= in_rd;
            data_mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_writeback_queue.sv
// tb_writeback_queue: directed vectors with literal expectations plus a
// queue-based reference model compared against the DUT on every negedge.
module tb_writeback_queue;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, alu_valid, drain_en, flush;
    logic [4:0]  mem_rd, alu_rd, q_addr1, q_addr2;
    logic [31:0] mem_data, alu_data;
    logic        mem_ready, alu_ready, rf_we, hit1, hit2;
    logic [4:0]  rf_addr;
    logic [31:0] rf_wd, fwd1, fwd2;
    logic [2:0]  count;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;
    ent_t mq[$];

    writeback_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .drain_en(drain_en), .flush(flush),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_wd(rf_wd),
        .q_addr1(q_addr1), .q_addr2(q_addr2),
        .hit1(hit1), .hit2(hit2), .fwd1(fwd1), .fwd2(fwd2),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Youngest pending write to addr, searched from the tail of the model queue.
    task automatic model_lookup(input logic [4:0] addr, output logic hit, output logic [31:0] d);
        hit = 1'b0;
        d   = '0;
        if (!rst && addr != 5'd0) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (mq[i].rd == addr) begin
                    hit = 1'b1;
                    d   = mq[i].data;
                    break;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        logic        e_mr, e_ar, e_we, e_h1, e_h2;
        logic [31:0] e_f1, e_f2;
        logic [4:0]  e_addr;
        logic [31:0] e_wd;
        if (chk_en) begin
            e_mr   = !rst && !flush && (mq.size() < DEPTH);
            e_ar   = e_mr && !mem_valid;
            e_we   = (mq.size() != 0) && drain_en && !flush && !rst;
            e_addr = (mq.size() != 0) ? mq[0].rd : 5'd0;
            e_wd   = (mq.size() != 0) ? mq[0].data : 32'd0;
            model_lookup(q_addr1, e_h1, e_f1);
            model_lookup(q_addr2, e_h2, e_f2);
            chk("mdl_mem_ready", 32'(mem_ready), 32'(e_mr));
            chk("mdl_alu_ready", 32'(alu_ready), 32'(e_ar));
            chk("mdl_rf_we", 32'(rf_we), 32'(e_we));
            chk("mdl_rf_addr", 32'(rf_addr), 32'(e_addr));
            chk("mdl_rf_wd", rf_wd, e_wd);
            chk("mdl_count", 32'(count), 32'(mq.size()));
            chk("mdl_hit1", 32'(hit1), 32'(e_h1));
            chk("mdl_fwd1", fwd1, e_f1);
            chk("mdl_hit2", 32'(hit2), 32'(e_h2));
            chk("mdl_fwd2", fwd2, e_f2);
            // Advance the model to the state after the coming edge.
            if (rst || flush) begin
                mq.delete();
            end else begin
                if (e_we) void'(mq.pop_front());
                if (mem_valid && e_mr) begin
                    if (mem_rd != 5'd0) mq.push_back({mem_rd, mem_data});
                end else if (alu_valid && e_ar) begin
                    if (alu_rd != 5'd0) mq.push_back({alu_rd, alu_data});
                end
            end
        end
    end

    task automatic nx();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic quiet();
        mem_valid = 1'b0; alu_valid = 1'b0; flush = 1'b0;
        mem_rd = '0; alu_rd = '0; mem_data = '0; alu_data = '0;
        q_addr1 = '0; q_addr2 = '0;
    endtask

    initial begin
        rst = 1'b1; drain_en = 1'b0;
        quiet();
        nx();
        chk_en = 1'b1;
        nx();
        rst = 1'b0;
        smp();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_rf_addr", 32'(rf_addr), 32'd0);
        chk("rst_rf_wd", rf_wd, 32'd0);
        chk("rst_mem_ready", 32'(mem_ready), 32'd1);

        // Single write, one-cycle latency.
        nx();
        drain_en = 1'b1;
        mem_valid = 1'b1; mem_rd = 5'd5; mem_data = 32'hDEADBEEF;
        smp();
        chk("single_rf_we_n", 32'(rf_we), 32'd0);
        nx(); quiet();
        smp();
        chk("single_rf_we", 32'(rf_we), 32'd1);
        chk("single_rf_addr", 32'(rf_addr), 32'd5);
        chk("single_rf_wd", rf_wd, 32'hDEADBEEF);
        nx();
        smp();
        chk("single_count_n2", 32'(count), 32'd0);

        // Priority: mem wins, alu taken next cycle, written in order.
        nx();
        mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h11;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h22;
        smp();
        chk("prio_mem_ready", 32'(mem_ready), 32'd1);
        chk("prio_alu_ready", 32'(alu_ready), 32'd0);
        nx(); mem_valid = 1'b0;
        smp();
        chk("prio_alu_ready2", 32'(alu_ready), 32'd1);
        chk("prio_wr1_addr", 32'(rf_addr), 32'd3);
        nx(); quiet();
        smp();
        chk("prio_wr2_addr", 32'(rf_addr), 32'd4);
        chk("prio_wr2_wd", rf_wd, 32'h22);

        // Full and wrap.
        nx(); drain_en = 1'b0;
        for (int r = 1; r <= 4; r++) begin
            mem_valid = 1'b1; mem_rd = 5'(r); mem_data = 32'h100 + 32'(r);
            smp();
            chk("full_push_ready", 32'(mem_ready), 32'd1);
            nx();
        end
        mem_rd = 5'd5; mem_data = 32'h105;
        smp();
        chk("full_count", 32'(count), 32'd4);
        chk("full_stall", 32'(mem_ready), 32'd0);
        nx(); drain_en = 1'b1;
        smp();
        chk("full_pop_stall", 32'(mem_ready), 32'd0);
        chk("full_wr1", 32'(rf_addr), 32'd1);
        nx();
        smp();
        chk("full_accept5", 32'(mem_ready), 32'd1);
        chk("full_wr2", 32'(rf_addr), 32'd2);
        nx(); quiet();
        for (int r = 3; r <= 5; r++) begin
            smp();
            chk("full_wr_seq", 32'(rf_addr), 32'(r));
            nx();
        end
        smp();
        chk("full_wr5_done", 32'(count), 32'd0);

        // Bypass.
        nx(); drain_en = 1'b0;
        mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'hA;
        nx(); mem_data = 32'hB; q_addr1 = 5'd7;
        smp();
        chk("byp_sameCycle_fwd1", fwd1, 32'hA);
        nx(); mem_valid = 1'b0; q_addr2 = 5'd0;
        smp();
        chk("byp_hit1", 32'(hit1), 32'd1);
        chk("byp_fwd1", fwd1, 32'hB);
        chk("byp_hit2", 32'(hit2), 32'd0);
        nx(); mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'hC; q_addr2 = 5'd9;
        smp();
        chk("byp_incoming_nohit", 32'(hit2), 32'd0);
        nx(); mem_valid = 1'b0; drain_en = 1'b1;
        smp();
        chk("byp_head_wr", 32'(rf_addr), 32'd7);
        chk("byp_head_hit", 32'(hit1), 32'd1);
        chk("byp_head_fwd", fwd1, 32'hB);
        chk("byp_fwd2", fwd2, 32'hC);
        for (int k = 0; k < 3; k++) nx();
        quiet();

        // Write to x0 is handshaken and dropped.
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFFFFFF;
        smp();
        chk("x0_alu_ready", 32'(alu_ready), 32'd1);
        nx(); quiet();
        smp();
        chk("x0_count", 32'(count), 32'd0);
        chk("x0_rf_we", 32'(rf_we), 32'd0);

        // Flush, then reset, with three pending entries.
        for (int pass = 0; pass < 2; pass++) begin
            nx(); drain_en = 1'b0;
            for (int r = 10; r < 13; r++) begin
                mem_valid = 1'b1; mem_rd = 5'(r); mem_data = 32'(r);
                nx();
            end
            mem_rd = 5'd13; drain_en = 1'b1; q_addr1 = 5'd10;
            if (pass == 0) flush = 1'b1; else rst = 1'b1;
            smp();
            chk("fl_mem_ready", 32'(mem_ready), 32'd0);
            chk("fl_rf_we", 32'(rf_we), 32'd0);
            nx(); quiet(); rst = 1'b0; q_addr1 = 5'd10;
            smp();
            chk("fl_count", 32'(count), 32'd0);
            chk("fl_hit1", 32'(hit1), 32'd0);
            chk("fl_rf_addr", 32'(rf_addr), 32'd0);
        end

        // Mixed traffic, checked by the model only.
        for (int c = 0; c < 400; c++) begin
            nx();
            mem_valid = 1'($urandom_range(0, 1));
            mem_rd    = 5'($urandom_range(0, 7));
            mem_data  = $urandom;
            alu_valid = 1'($urandom_range(0, 1));
            alu_rd    = 5'($urandom_range(0, 7));
            alu_data  = $urandom;
            drain_en  = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            rst       = ($urandom_range(0, 49) == 0);
            q_addr1   = 5'($urandom_range(0, 7));
            q_addr2   = 5'($urandom_range(0, 7));
        end
        nx(); quiet(); rst = 1'b0;
        smp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
